instr_reg_sched: RTL and testbench
==================================

# instr_reg_sched

Write-arbiter and occupancy controller that shares the `instr_register` load port between two instruction producers and sequences reads out of it in FIFO order. It drives `load_en`, `write_pointer` and instruction data into the register, plus `read_pointer` on the read side. It tracks occupancy, stalls producers when the register is full, and counts rejected requests. It sits between the producers and `instr_register` in the top-level netlist; in `top`, the consumer is the test program.

## Interface
Parameters:
- NUM_ENTRIES, 32: register depth; must equal 2**$bits(address_t).
- DROP_W, 8: width of the saturating drop counter.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req_a, req_b  in  1  producer write requests, level.
- instr_a, instr_b  in  instruction_t  producer instruction payloads.
- gnt_a, gnt_b  out  1  write grant; combinational, at most one high per cycle.
- load_en  out  1  write strobe to instr_register; equals gnt_a | gnt_b.
- write_pointer  out  address_t  write address, the registered wr_ptr.
- wr_instr  out  instruction_t  instruction selected by the grant; all-zero when no grant.
- read_pointer  out  address_t  read address, the registered rd_ptr.
- rd_valid  out  1  the entry at read_pointer is valid.
- rd_ready  in  1  consumer accepts the entry.
- hold  in  1  freeze request, level.
- flush  in  1  clear request, sampled on clk.
- count  out  $clog2(NUM_ENTRIES)+1  occupancy, 0..NUM_ENTRIES.
- full, empty  out  1  count==NUM_ENTRIES and count==0.
- drop_cnt  out  DROP_W  number of request-cycles denied because the register was full.

## Operation
- State machine states are RUN, HOLD and FLUSH. The same transitions apply in every state:
  - flush=1 → FLUSH.
  - FLUSH → HOLD if hold=1, else RUN.
  - RUN with hold=1 → HOLD.
  - HOLD with hold=0 → RUN.
- Grant eligibility: the state is RUN, flush=0, reset=0 and full=0.
- Round-robin arbitration uses a prio register, reset value A.
  - If only one requester is eligible, it is granted.
  - If both request, the requester named by prio is granted.
  - After any grant, prio points to the other requester.
  - prio is unchanged when no grant is issued.
- Push occurs when load_en=1. At the clk edge, wr_ptr increments and wraps from NUM_ENTRIES-1 to 0.
- rd_valid = (state==RUN) & !empty & !flush.
- Pop occurs when rd_valid & rd_ready. At the clk edge, rd_ptr increments with wrap.
- count update:
  - push without pop: +1.
  - pop without push: -1.
  - push and pop together: unchanged, and both pointers advance.
- Full with a simultaneous pop: the grant is still denied, because full is computed from the registered count.
- drop_cnt increments each cycle in which the state is RUN, flush=0, full=1 and (req_a|req_b). It saturates at 2**DROP_W-1 and is cleared only by reset.
- flush clears wr_ptr, rd_ptr and count at the same edge. Grants and pops are suppressed in the flush cycle and during the FLUSH state. prio and drop_cnt are kept.

## Timing
- Grant and load_en are combinational with zero latency. instr_register captures the write on the same clk edge as the pointer increment.
- After a push into an empty register, rd_valid rises one cycle later.
- Reset (asynchronous) sets:
  - state=RUN, wr_ptr=0, rd_ptr=0, count=0, prio=A, drop_cnt=0.
  - gnt_a, gnt_b, load_en and rd_valid forced to 0 while reset=1; wr_instr=0.
  - empty=1, full=0.
- Reset asserted mid-burst: all in-flight state is discarded immediately. Stored register contents are not scrubbed.

## Structure
- In instr_register_pkg:
  - sched_state_t enum {RUN, HOLD, FLUSH}.
  - NUM_ENTRIES constant.
  - The existing instruction_t and address_t.
- Sub-module rr_arbiter_2 implements the 2-way round-robin grant logic and owns the prio register.
- In top, instr_reg_sched is wired between the producers and instr_register through tb_ifc.

## Test plan
- Reset: assert reset for 3 cycles, then release → count=0, empty=1, full=0, write_pointer=0, read_pointer=0, drop_cnt=0, gnt_a=gnt_b=0.
- Contention: req_a=req_b=1 for 4 cycles from reset with rd_ready=0 → grant order A,B,A,B; write_pointer 0,1,2,3; count=4.
- Full/drop: push 32 entries, then hold req_a=1 for 300 cycles →
  - full=1 and gnt_a=0.
  - drop_cnt counts 1..255, then stays at 255.
  - rd_ready=1 for one cycle → count=31, and gnt_a returns on the next cycle.
- Simultaneous push/pop and wrap: at count=5, req_a=1 and rd_ready=1 for 40 cycles → count stays 5, and both pointers wrap from 31 to 0.
- Hold: count=3, hold=1 with req_b=1 and rd_ready=1 → gnt_b=0, rd_valid=0, count=3. After hold is released, pops resume the next cycle.
- Flush mid-traffic: count=10, req_a=1, flush pulsed for 1 cycle →
  - no grant in the flush cycle or the FLUSH cycle.
  - count=0 and both pointers=0 after that edge.
  - RUN resumes with a grant to A.

Source files
------------

// File: rtl/instr_reg_sched_pkg.sv
// Shared types and constants for the instruction-register write scheduler.
// Depth, pointer/count widths, instruction layout and scheduler states live here.
package instr_reg_sched_pkg;

  localparam int NUM_ENTRIES = 32;
  localparam int ADDR_W      = $clog2(NUM_ENTRIES);
  localparam int CNT_W       = ADDR_W + 1;

  typedef logic [ADDR_W-1:0] address_t;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } sched_state_t;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  // Pointer advance with explicit wrap so a non-power-of-two depth would still be safe.
  function automatic address_t ptr_inc(address_t p);
    return (p == address_t'(NUM_ENTRIES - 1)) ? '0 : p + address_t'(1);
  endfunction

endpackage

// File: rtl/instr_reg_sched_if.sv
// Producer/consumer/register-port bundle around instr_reg_sched.
// master = environment (producers, consumer, control); slave = the scheduler.
interface instr_reg_sched_if
  import instr_reg_sched_pkg::*;
#(
  parameter int DROP_W = 8
);

  logic               req_a;
  logic               req_b;
  instruction_t       instr_a;
  instruction_t       instr_b;
  logic               gnt_a;
  logic               gnt_b;
  logic               load_en;
  address_t           write_pointer;
  instruction_t       wr_instr;
  address_t           read_pointer;
  logic               rd_valid;
  logic               rd_ready;
  logic               hold;
  logic               flush;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic [DROP_W-1:0]  drop_cnt;

  modport master (
    output req_a, req_b, instr_a, instr_b, rd_ready, hold, flush,
    input  gnt_a, gnt_b, load_en, write_pointer, wr_instr, read_pointer,
           rd_valid, count, full, empty, drop_cnt
  );

  modport slave (
    input  req_a, req_b, instr_a, instr_b, rd_ready, hold, flush,
    output gnt_a, gnt_b, load_en, write_pointer, wr_instr, read_pointer,
           rd_valid, count, full, empty, drop_cnt
  );

endinterface

// File: rtl/instr_reg_sched_rr_arbiter_2.sv
// Two-way round-robin grant with a single priority flop.
// Requests arrive already qualified; grants are combinational, prio flips after each grant.
module rr_arbiter_2
  import instr_reg_sched_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  prio_t prio;

  always_comb begin
    gnt_a = req_a & (~req_b | (prio == PRIO_A));
    gnt_b = req_b & (~req_a | (prio == PRIO_B));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio <= PRIO_A;
    end else if (gnt_a) begin
      prio <= PRIO_B;
    end else if (gnt_b) begin
      prio <= PRIO_A;
    end
  end

endmodule

// File: rtl/instr_reg_sched.sv
// Shares the instr_register load port between two producers and walks reads out in FIFO order.
// Tracks occupancy, stalls producers when full and counts denied request-cycles.
//
//   state | meaning
//   RUN   | grants and pops allowed
//   HOLD  | frozen: no grants, no pops, pointers and count kept
//   FLUSH | one-cycle recovery after a flush; pointers and count already cleared
module instr_reg_sched
  import instr_reg_sched_pkg::*;
#(
  parameter int NUM_ENTRIES = instr_reg_sched_pkg::NUM_ENTRIES,
  parameter int DROP_W      = 8
)(
  input  logic               clk,
  input  logic               reset,
  instr_reg_sched_if.slave   bus
);

  if (NUM_ENTRIES != 2 ** $bits(address_t)) begin : g_depth_check
    $error("NUM_ENTRIES must equal 2**$bits(address_t)");
  end

  sched_state_t        state;
  address_t            wr_ptr;
  address_t            rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [DROP_W-1:0]   drop_cnt;

  logic full;
  logic empty;
  logic eligible;
  logic gnt_a;
  logic gnt_b;
  logic push;
  logic rd_valid;
  logic pop;
  logic drop_hit;

  // full comes from the registered count, so a pop in the same cycle cannot reopen the port.
  assign full     = (count == CNT_W'(NUM_ENTRIES));
  assign empty    = (count == '0);
  assign eligible = (state == RUN) & ~bus.flush & ~reset & ~full;

  rr_arbiter_2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req_a (bus.req_a & eligible),
    .req_b (bus.req_b & eligible),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  assign push     = gnt_a | gnt_b;
  assign rd_valid = (state == RUN) & ~empty & ~bus.flush & ~reset;
  assign pop      = rd_valid & bus.rd_ready;
  assign drop_hit = (state == RUN) & ~bus.flush & full & (bus.req_a | bus.req_b);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (bus.flush) begin
        state  <= FLUSH;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        case (state)
          RUN:     if (bus.hold)  state <= HOLD;
          HOLD:    if (!bus.hold) state <= RUN;
          FLUSH:   state <= bus.hold ? HOLD : RUN;
          default: state <= RUN;
        endcase

        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);

        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end

      // Saturating; only reset clears it, flush deliberately leaves it alone.
      if (drop_hit && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

  always_comb begin
    bus.wr_instr = '0;
    if (gnt_a) begin
      bus.wr_instr = bus.instr_a;
    end else if (gnt_b) begin
      bus.wr_instr = bus.instr_b;
    end
  end

  assign bus.gnt_a         = gnt_a;
  assign bus.gnt_b         = gnt_b;
  assign bus.load_en       = push;
  assign bus.write_pointer = wr_ptr;
  assign bus.read_pointer  = rd_ptr;
  assign bus.rd_valid      = rd_valid;
  assign bus.count         = count;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.drop_cnt      = drop_cnt;

endmodule

// File: tb/tb_instr_reg_sched.sv
// Randomized scoreboard bench for instr_reg_sched with a queue-based reference model
// and a behavioural instr_register so read order can be checked end to end.
module tb_instr_reg_sched;
  import instr_reg_sched_pkg::*;

  localparam int DROP_W   = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_reg_sched_if #(.DROP_W(DROP_W)) bus ();

  instr_reg_sched #(.NUM_ENTRIES(NUM_ENTRIES), .DROP_W(DROP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Stand-in for instr_register: captures on the same edge as the pointer increment.
  instruction_t mem [NUM_ENTRIES];
  always @(posedge clk) begin
    if (bus.load_en) mem[bus.write_pointer] <= bus.wr_instr;
  end

  typedef struct {
    logic         ga;
    logic         gb;
    int           cnt;
    logic         rv;
    int           wp;
    int           rp;
    int           drop;
    instruction_t wi;
  } exp_t;

  exp_t         exp_q[$];
  instruction_t rd_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: occupancy is the length of a queue of stored instructions.
  instruction_t m_q[$];
  int           m_mode;   // 0 running, 1 frozen, 2 recovering from flush
  bit           m_prio_b;
  int           m_wp;
  int           m_rp;
  int           m_drop;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  function automatic instruction_t rand_instr();
    logic [95:0] raw;
    raw = {$urandom, $urandom, $urandom};
    return instruction_t'(raw[$bits(instruction_t)-1:0]);
  endfunction

  function automatic bit pct(int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    rd_q.delete();
    m_mode   = 0;
    m_prio_b = 1'b0;
    m_wp     = 0;
    m_rp     = 0;
    m_drop   = 0;
  endfunction

  task automatic step(input bit ra, input bit rb, input bit rr, input bit h, input bit f, input bit r);
    instruction_t ia, ib;
    exp_t e;
    bit full_m, elig, ga, gb, rv;
    @(posedge clk);
    #1;
    ia = rand_instr();
    ib = rand_instr();
    reset        = r;
    bus.req_a    = ra;
    bus.req_b    = rb;
    bus.instr_a  = ia;
    bus.instr_b  = ib;
    bus.rd_ready = rr;
    bus.hold     = h;
    bus.flush    = f;
    e.wi = '0;
    if (r) begin
      model_reset();
      e.ga = 0; e.gb = 0; e.cnt = 0; e.rv = 0; e.wp = 0; e.rp = 0; e.drop = 0;
    end else begin
      full_m = (m_q.size() == NUM_ENTRIES);
      elig   = (m_mode == 0) && !f && !full_m;
      ga     = elig && ra && (!rb || !m_prio_b);
      gb     = elig && rb && (!ra || m_prio_b);
      rv     = (m_mode == 0) && (m_q.size() != 0) && !f;
      e.ga = ga; e.gb = gb; e.cnt = m_q.size(); e.rv = rv;
      e.wp = m_wp; e.rp = m_rp; e.drop = m_drop;
      if (ga) e.wi = ia;
      else if (gb) e.wi = ib;
      if ((m_mode == 0) && !f && full_m && (ra || rb) && (m_drop < DROP_MAX)) m_drop++;
      if (f) begin
        m_q.delete();
        m_wp = 0;
        m_rp = 0;
        m_mode = 2;
      end else begin
        if (rv && rr) begin
          rd_q.push_back(m_q.pop_front());
          m_rp = (m_rp + 1) % NUM_ENTRIES;
        end
        if (ga || gb) begin
          m_q.push_back(ga ? ia : ib);
          m_wp = (m_wp + 1) % NUM_ENTRIES;
          m_prio_b = ga;
        end
        if (m_mode == 2) m_mode = h ? 1 : 0;
        else if ((m_mode == 0) && h) m_mode = 1;
        else if ((m_mode == 1) && !h) m_mode = 0;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input int pa, input int pb, input int pr, input int ph, input int pf);
    for (int i = 0; i < n; i++) begin
      step(pct(pa), pct(pb), pct(pr), pct(ph), pct(pf), 1'b0);
    end
  endtask

  // Monitor: pops one expectation per presented cycle, plus read data on each accepted pop.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) continue;
      e = exp_q.pop_front();
      chk("gnt_a",         bus.gnt_a,         e.ga);
      chk("gnt_b",         bus.gnt_b,         e.gb);
      chk("load_en",       bus.load_en,       e.ga | e.gb);
      chk("count",         bus.count,         e.cnt);
      chk("full",          bus.full,          e.cnt == NUM_ENTRIES);
      chk("empty",         bus.empty,         e.cnt == 0);
      chk("rd_valid",      bus.rd_valid,      e.rv);
      chk("write_pointer", bus.write_pointer, e.wp);
      chk("read_pointer",  bus.read_pointer,  e.rp);
      chk("drop_cnt",      bus.drop_cnt,      e.drop);
      chk("wr_instr",      bus.wr_instr,      e.wi);
      if (bus.rd_valid && bus.rd_ready) begin
        if (rd_q.size() == 0) chk("rd_data_pending", 0, 1);
        else chk("rd_data", mem[bus.read_pointer], rd_q.pop_front());
      end
    end
  end

  initial begin
    bus.req_a    = 1'b0;
    bus.req_b    = 1'b0;
    bus.instr_a  = '0;
    bus.instr_b  = '0;
    bus.rd_ready = 1'b0;
    bus.hold     = 1'b0;
    bus.flush    = 1'b0;
    model_reset();

    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, 1);
    step(1, 0, 1, 0, 0, 1);

    run(4, 100, 100, 0, 0, 0);      // contention from reset: A,B,A,B
    run(330, 100, 0, 0, 0, 0);      // fill, then saturate drop_cnt
    run(1, 100, 0, 100, 0, 0);      // single pop while full
    run(3, 100, 0, 0, 0, 0);        // A regains the port
    run(27, 0, 0, 100, 0, 0);       // drain to 5
    run(40, 100, 0, 100, 0, 0);     // steady push+pop across the wrap
    run(30, 0, 0, 100, 0, 0);
    run(3, 100, 0, 0, 0, 0);        // count 3
    run(4, 0, 100, 100, 100, 0);    // frozen
    run(3, 0, 0, 100, 0, 0);        // pops resume
    run(10, 100, 0, 0, 0, 0);
    run(1, 100, 0, 0, 0, 100);      // flush mid-traffic
    run(3, 100, 0, 0, 0, 0);

    run(1500, 60, 60, 50, 8, 2);
    step(1, 1, 1, 0, 0, 1);         // reset mid-burst
    run(1500, 80, 80, 30, 5, 1);
    run(60, 100, 100, 0, 0, 0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("rd_queue_drained",   rd_q.size(),  0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
